// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state enum, default sizing, widths and an alignment helper.
package imem_pkg;

    localparam int DEF_MEM_BYTES    = 1024;
    localparam int DEF_READ_LATENCY = 4;
    localparam int CNT_W            = 4;
    localparam int ADDR_W           = 10;
    localparam int LOAD_AW          = 8;
    localparam int DATA_W           = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic word_aligned(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_if.sv
// CPU-side fetch bus plus program-load port of the instruction memory.
// master: CPU / loader (drives requests), slave: imem_responder.
interface imem_if;
    import imem_pkg::*;

    logic               READ;
    logic [ADDR_W-1:0]  ADDRESS;
    logic               LOAD_EN;
    logic [LOAD_AW-1:0] LOAD_ADDR;
    logic [DATA_W-1:0]  LOAD_DATA;
    logic [DATA_W-1:0]  READDATA;
    logic               BUSYWAIT;
    logic               ERROR;

    modport master (
        output READ, ADDRESS,
        output LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  READDATA, BUSYWAIT, ERROR
    );

    modport slave (
        input  READ, ADDRESS,
        input  LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output READDATA, BUSYWAIT, ERROR
    );

endinterface

// File: rtl/imem_array.sv
// Byte-addressed little-endian instruction storage, not cleared by reset.
// Ports: clk, we/waddr(word index)/wdata write port, raddr(byte)/rdata read.
module imem_array
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LOAD_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [DATA_W-1:0]  rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] rb;
    logic [AW-1:0] wb;

    assign rb = AW'(raddr);
    assign wb = AW'({waddr, 2'b00});

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wb]          <= wdata[7:0];
            mem[wb + AW'(1)] <= wdata[15:8];
            mem[wb + AW'(2)] <= wdata[23:16];
            mem[wb + AW'(3)] <= wdata[31:24];
        end
    end

    // Asynchronous read: a write on the same edge is seen only afterwards.
    assign rdata = {
        mem[rb + AW'(3)],
        mem[rb + AW'(2)],
        mem[rb + AW'(1)],
        mem[rb]
    };

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction fetch responder with IDLE/BUSY/DONE handshake.
// Ports: CLK, RESET (async, active-high), bus (imem_if.slave).
module imem_responder
    import imem_pkg::*;
#(
    parameter int MEM_BYTES    = DEF_MEM_BYTES,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic  CLK,
    input  logic  RESET,
    imem_if.slave bus
);

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rdata_d;
    logic               err_q;
    logic               err_d;
    logic               busy;
    logic [DATA_W-1:0]  arr_rdata;

    imem_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk   (CLK),
        .we    (bus.LOAD_EN),
        .waddr (bus.LOAD_ADDR),
        .wdata (bus.LOAD_DATA),
        .raddr (addr_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        busy    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = bus.READ;
                if (bus.READ) begin
                    if (word_aligned(bus.ADDRESS)) begin
                        addr_d  = bus.ADDRESS;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = BUSY;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    rdata_d = arr_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset already forces IDLE, where busy follows READ; mask it here.
    assign bus.BUSYWAIT = busy & ~RESET;
    assign bus.READDATA = rdata_q;
    assign bus.ERROR    = err_q;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, meaning instruction storage size in bytes.
REQ-002 The block SHALL have parameter READ_LATENCY, default 4, meaning the number of BUSY cycles per fetch (legal 1..15).
REQ-003 The block SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port READ  input  1  fetch request from CPU.
REQ-006 The block SHALL have port ADDRESS  input  10  byte address of the requested instruction (the CPU PC).
REQ-007 The block SHALL have port LOAD_EN  input  1  program-load word-write strobe.
REQ-008 The block SHALL have port LOAD_ADDR  input  8  word index for program load.
REQ-009 The block SHALL have port LOAD_DATA  input  32  instruction word for program load.
REQ-010 The block SHALL have port READDATA  output  32  fetched instruction.
REQ-011 The block SHALL have port BUSYWAIT  output  1  stall request to CPU.
REQ-012 The block SHALL have port ERROR  output  1  misaligned-fetch flag.

Function
REQ-013 Storage SHALL be byte-addressed, little-endian: READDATA = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: BUSYWAIT SHALL equal READ combinationally, so the CPU stalls in the request cycle.
REQ-016 IDLE, READ=1, ADDRESS[1:0]=0 at the clock edge: latch ADDRESS, load counter with READ_LATENCY-1, go to BUSY.
REQ-017 IDLE, READ=1, ADDRESS[1:0]!=0 at the clock edge: go to DONE with READDATA=32'h0 and ERROR=1.
REQ-018 BUSY: BUSYWAIT=1; counter SHALL decrement each edge.
REQ-019 BUSY, counter=0 at the clock edge: READDATA <= word at latched address, ERROR <= 0, go to DONE; BUSY therefore lasts exactly READ_LATENCY cycles.
REQ-020 DONE: BUSYWAIT=0 for exactly one cycle, READDATA valid; the next edge SHALL return to IDLE unconditionally.
REQ-021 A CPU holding READ=1 into the following IDLE cycle SHALL start a new fetch.
REQ-022 READDATA and ERROR SHALL hold their values until the next fetch completes.
REQ-023 ADDRESS changes and READ deassertion during BUSY SHALL be ignored; the fetch completes.
REQ-024 LOAD_EN=1 SHALL write LOAD_DATA to bytes 4*LOAD_ADDR..+3 at the edge, in any state.
REQ-025 A write at the same edge as a BUSY completion to the same word SHALL return the old data; earlier writes SHALL be visible.

Reset
REQ-026 RESET=1 SHALL immediately force state=IDLE, counter=0, READDATA=32'h0, ERROR=0, and BUSYWAIT=0 regardless of READ.
REQ-027 Reset mid-fetch SHALL abort the fetch with no DONE cycle.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-029 Package imem_pkg SHALL hold the state enum, the default MEM_BYTES/READ_LATENCY constants, and the counter width (4).
REQ-030 Sub-module imem_array SHALL contain the byte storage with one word read port and one word write port; the FSM, counter, and output registers SHALL live in imem_responder.

Verification
REQ-031 Load word 0=32'h08010010, then READ=1 with ADDRESS=0 at cycle 0 (L=4) -> BUSYWAIT high in cycles 0-4, low in cycle 5, READDATA=32'h08010010, ERROR=0.
REQ-032 Back-to-back fetch: READ held high, ADDRESS 0->4 in the DONE cycle, word 1=32'h08020010 -> second DONE 6 cycles after the first, READDATA=32'h08020010.
REQ-033 READ with ADDRESS=10'd6 -> BUSYWAIT high for one cycle, then DONE with ERROR=1 and READDATA=0.
REQ-034 RESET pulse during BUSY cycle 2 -> BUSYWAIT=0 immediately, READDATA=0, no DONE; refetch of ADDRESS=0 returns preloaded data.
REQ-035 LOAD_EN to word 3 (32'h00010003) at the completion edge of a fetch of ADDRESS=12 -> old value returned; the next fetch returns 32'h00010003.
REQ-036 With READ_LATENCY=1, READ at ADDRESS=0 -> exactly one BUSY cycle, data valid in cycle 2.
